// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen_if
// Brief    : Timing-in / pixel-out bundle for the VGA test-pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 1
);
    logic [9:0]           h_count;
    logic [9:0]           v_count;
    logic                 bright;
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] rgb;
    logic                 bright_q;
    logic                 frame_tick;

    modport master (
        output h_count, v_count, bright, mode,
        input  rgb, bright_q, frame_tick
    );

    modport slave (
        input  h_count, v_count, bright, mode,
        output rgb, bright_q, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Brief    : Registered VGA test patterns (frame, bars, checker, bouncing box).
// Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int COLOR_W    = 1,
    parameter int H_START    = 160,
    parameter int H_TOTAL    = 800,
    parameter int V_START    = 41,
    parameter int V_TOTAL    = 521,
    parameter int BORDER     = 10,
    parameter int BAR_W      = 80,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 32,
    parameter int STEP       = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    vga_pattern_gen_if.slave bus
);
    localparam logic [10:0] c_H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_H_START = 11'(H_START);
    localparam logic [10:0] c_V_START = 11'(V_START);
    localparam logic [10:0] c_H_LO    = 11'(H_START + BORDER);
    localparam logic [10:0] c_H_HI    = 11'(H_TOTAL - BORDER);
    localparam logic [10:0] c_V_LO    = 11'(V_START + BORDER);
    localparam logic [10:0] c_V_HI    = 11'(V_TOTAL - BORDER);
    localparam logic [10:0] c_BOX     = 11'(BOX_SIZE);
    localparam logic [9:0]  c_XMAX    = 10'(H_TOTAL - H_START - BOX_SIZE);
    localparam logic [9:0]  c_YMAX    = 10'(V_TOTAL - V_START - BOX_SIZE);

    logic [1:0]           r_mode;
    logic [9:0]           r_box_x;
    logic [9:0]           r_box_y;
    logic                 r_dir_x;
    logic                 r_dir_y;
    logic [3*COLOR_W-1:0] r_rgb;
    logic                 r_bright_q;
    logic                 r_frame_tick;

    logic [10:0] w_h;
    logic [10:0] w_v;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_eof;
    logic        w_in_box;
    logic [2:0]  w_bar;
    logic [2:0]  w_color;
    logic [10:0] w_nx;
    logic [10:0] w_ny;

    // Returns {next_dir, next_pos}; bounces clamp to the edge and reverse.
    function automatic logic [10:0] f_step(input logic [9:0] i_pos,
                                           input logic       i_dir,
                                           input logic [9:0] i_max);
        if (i_dir) begin
            if (({1'b0, i_pos} + 11'(STEP)) >= {1'b0, i_max})
                f_step = {1'b0, i_max};
            else
                f_step = {1'b1, i_pos + 10'(STEP)};
        end else begin
            if (i_pos <= 10'(STEP))
                f_step = {1'b1, 10'd0};
            else
                f_step = {1'b0, i_pos - 10'(STEP)};
        end
    endfunction

    assign w_h   = {1'b0, bus.h_count};
    assign w_v   = {1'b0, bus.v_count};
    assign w_x   = w_h - c_H_START;
    assign w_y   = w_v - c_V_START;
    assign w_eof = (w_h == c_H_LAST) && (w_v == c_V_LAST);
    assign w_nx  = f_step(r_box_x, r_dir_x, c_XMAX);
    assign w_ny  = f_step(r_box_y, r_dir_y, c_YMAX);

    assign w_in_box = (w_x >= {1'b0, r_box_x}) && (w_x < ({1'b0, r_box_x} + c_BOX)) &&
                      (w_y >= {1'b0, r_box_y}) && (w_y < ({1'b0, r_box_y} + c_BOX));

    always_comb begin
        w_bar   = 3'd0;
        w_color = 3'b000;
        for (int i = 1; i < 8; i++) begin
            if (w_x >= 11'(i * BAR_W))
                w_bar = 3'(i);
        end
        if (bus.bright) begin
            case (r_mode)
                2'd0: w_color = ((w_h >= c_H_LO) && (w_h <= c_H_HI) &&
                                 (w_v >= c_V_LO) && (w_v <= c_V_HI)) ? 3'b100 : 3'b111;
                2'd1: w_color = w_bar;
                2'd2: w_color = (w_x[CHECK_LOG2] ^ w_y[CHECK_LOG2]) ? 3'b000 : 3'b111;
                default: w_color = w_in_box ? 3'b111 : 3'b001;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb        <= '0;
            r_bright_q   <= 1'b0;
            r_frame_tick <= 1'b0;
            r_mode       <= 2'd0;
            r_box_x      <= 10'd0;
            r_box_y      <= 10'd0;
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b1;
        end else begin
            r_rgb        <= {{COLOR_W{w_color[2]}}, {COLOR_W{w_color[1]}}, {COLOR_W{w_color[0]}}};
            r_bright_q   <= bus.bright;
            r_frame_tick <= w_eof;
            // The pixel above used the pre-update mode and box position.
            if (w_eof) begin
                r_mode             <= bus.mode;
                {r_dir_x, r_box_x} <= w_nx;
                {r_dir_y, r_box_y} <= w_ny;
            end
        end
    end

    assign bus.rgb        = r_rgb;
    assign bus.bright_q   = r_bright_q;
    assign bus.frame_tick = r_frame_tick;
endmodule
`default_nettype wire
